rotary_decoder: RTL and testbench
=================================

ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter C_DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required before a filtered input changes (legal range 2..65535).
REQ-002 Parameter C_CNT_WIDTH, default 16, width of the position counter (legal range 4..32).
REQ-003 SPLB_Clk  in  1  sole clock; all state on the rising edge.
REQ-004 SPLB_Rst_n  in  1  asynchronous, active-low reset.
REQ-005 rotary_a  in  1  raw encoder phase A from the pad, asynchronous to SPLB_Clk.
REQ-006 rotary_b  in  1  raw encoder phase B from the pad, asynchronous to SPLB_Clk.
REQ-007 rotary_press  in  1  raw encoder push switch, asynchronous, 1 = pressed.
REQ-008 clr_pos  in  1  single-cycle strobe from the register file; clears position and quad_err.
REQ-009 step_valid  out  1  one-cycle pulse per decoded detent.
REQ-010 step_dir  out  1  direction of the last step, 1 = clockwise; valid with step_valid and held until the next step.
REQ-011 position  out  C_CNT_WIDTH  two's-complement detent count.
REQ-012 press_level  out  1  debounced push-switch level.
REQ-013 press_event  out  1  one-cycle pulse on each debounced press (0->1).
REQ-014 quad_err  out  1  sticky flag; an illegal quadrature transition was seen.

Function
REQ-015 Each raw input passes through a two-flop synchronizer before any other use.
REQ-016 Each synchronized input has its own debounce counter, its own filtered bit, and a mismatch condition (synchronized value differs from the filtered bit).
REQ-017 Counter behaviour: cleared on any cycle without a mismatch; incremented on each mismatch cycle; the filtered bit toggles on the cycle the counter reaches C_DEBOUNCE_CYCLES, and the counter clears on that same cycle.
REQ-018 Latency from a raw edge to the filtered change is 2 + C_DEBOUNCE_CYCLES cycles, +/-1 cycle for metastability resolution.
REQ-019 A glitch shorter than C_DEBOUNCE_CYCLES synchronized cycles shall not change any filtered bit.
REQ-020 The quadrature decoder samples the filtered pair {A,B}; the rest (detent) state is 00.
REQ-021 Clockwise sequence: 00->10->11->01->00. Counter-clockwise sequence: 00->01->11->10->00.
REQ-022 A signed 3-bit phase accumulator ph tracks progress: +1 on a legal CW transition, -1 on a legal CCW transition, unchanged when {A,B} is unchanged.
REQ-023 On entering 00 with ph reaching +4: step_valid=1 and step_dir=1 the following cycle. With ph reaching -4: step_valid=1 and step_dir=0. With any other ph value: no step. ph returns to 0 in all three cases.
REQ-024 Partial rotation followed by backtracking to 00 produces no step and leaves position unchanged.
REQ-025 Illegal transition (A and B both change in one cycle): quad_err is set, ph is cleared to 0, and no step is produced.
REQ-026 On each step, position is incremented (CW) or decremented (CCW), wrapping modulo 2^C_CNT_WIDTH with no saturation.
REQ-027 clr_pos forces position=0 and quad_err=0 the next cycle; clr_pos does not affect ph or the debounce state.
REQ-028 clr_pos coincident with a step: the clear wins (position=0), and step_valid/step_dir are still issued normally.
REQ-029 clr_pos coincident with an illegal transition: quad_err ends at 1 (the set wins).
REQ-030 press_level equals the filtered press bit. press_event is high for exactly one cycle, the cycle after press_level rises; nothing happens on release.
REQ-031 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-032 While SPLB_Rst_n=0, all of the following are 0: synchronizers, debounce counters, filtered bits, ph, step_valid, step_dir, position, press_level, press_event, quad_err.
REQ-033 Reset asserted mid-debounce or mid-rotation abandons the partial progress; no step or event is emitted after release.
REQ-034 After reset release, a raw input held at 1 is filtered to 1 after the normal latency. A resulting filtered {A,B} change from 00 is decoded as an ordinary transition.

Verification
REQ-035 C_DEBOUNCE_CYCLES=4. Drive the CW sequence with each phase held 10 cycles from position=0 -> exactly one step_valid pulse, step_dir=1, position=1.
REQ-036 C_DEBOUNCE_CYCLES=4. Pulse rotary_a high for 3 cycles, then low -> filtered A never changes, step_valid stays 0, position stays 0.
REQ-037 From position=0, drive the CCW sequence -> step_dir=0, position=16'hFFFF. Then drive two CW sequences -> position=16'h0001.
REQ-038 From filtered 00, change A and B together to 11 -> quad_err=1 with no step. Then clr_pos=1 for one cycle -> quad_err=0 and position=0.
REQ-039 Drive 00->10->11->10->00 -> no step, position unchanged, quad_err=0. Separately, assert clr_pos in the same cycle as the CW entry to 00 -> step_valid=1 and position=0.
REQ-040 Hold rotary_press high for 20 cycles -> press_level=1, with exactly one press_event pulse. Assert SPLB_Rst_n=0 mid-hold -> all outputs are 0 immediately.

Source files
------------

// File: rtl/rotary_decoder.sv
// rotary_decoder
// Quadrature rotary-encoder front end: synchronizes and debounces the two
// encoder phases and the push switch, decodes full detent steps from the
// filtered phase pair, and keeps a wrapping detent position count.
//
// Parameters
//   C_DEBOUNCE_CYCLES  stable cycles needed before a filtered bit changes (2..65535)
//   C_CNT_WIDTH        width of the position counter (4..32)
// Ports
//   SPLB_Clk       in   clock, rising edge
//   SPLB_Rst_n     in   asynchronous active-low reset
//   rotary_a/b     in   raw encoder phases (asynchronous)
//   rotary_press   in   raw push switch, 1 = pressed (asynchronous)
//   clr_pos        in   strobe: clears position and quad_err
//   step_valid     out  one-cycle pulse per detent
//   step_dir       out  direction of last step, 1 = clockwise (held)
//   position       out  two's-complement detent count
//   press_level    out  debounced push-switch level
//   press_event    out  one-cycle pulse after each debounced press
//   quad_err       out  sticky illegal-transition flag
module rotary_decoder #(
  parameter int C_DEBOUNCE_CYCLES = 1000,
  parameter int C_CNT_WIDTH       = 16
) (
  input  logic                   SPLB_Clk,
  input  logic                   SPLB_Rst_n,
  input  logic                   rotary_a,
  input  logic                   rotary_b,
  input  logic                   rotary_press,
  input  logic                   clr_pos,
  output logic                   step_valid,
  output logic                   step_dir,
  output logic [C_CNT_WIDTH-1:0] position,
  output logic                   press_level,
  output logic                   press_event,
  output logic                   quad_err
);

  localparam int DB_W = 16;
  localparam logic [DB_W:0] DB_LIMIT = C_DEBOUNCE_CYCLES[DB_W:0];
  localparam logic signed [2:0] PH_MAX = 3'sd3;
  localparam logic signed [2:0] PH_MIN = -3'sd3;
  localparam logic [C_CNT_WIDTH-1:0] POS_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Gray-code phase index along the clockwise sequence 00->10->11->01.
  function automatic logic [1:0] phase_idx(input logic a, input logic b);
    logic [1:0] idx;
    case ({a, b})
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      2'b01:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Bit 0 = phase A, bit 1 = phase B, bit 2 = push switch.
  logic [2:0] raw_s;
  assign raw_s = {rotary_press, rotary_b, rotary_a};

  logic [2:0]            meta_q, sync_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            ab_prev_q;
  logic signed [2:0]     ph_q, ph_d;
  logic                  press_prev_q;
  logic                  step_valid_q, step_valid_d;
  logic                  step_dir_q, step_dir_d;
  logic [C_CNT_WIDTH-1:0] position_q, position_d;
  logic                  press_event_q, press_event_d;
  logic                  quad_err_q, quad_err_d;

  logic [1:0] diff_s;
  logic       at_rest_s;
  logic       step_s, step_cw_s, illegal_s;

  // Debounce: count consecutive mismatch cycles per input, flip the filtered bit at the limit.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = {3{{DB_W{1'b0}}}};
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (({1'b0, db_cnt_q[i]} + 17'd1) == DB_LIMIT) begin
          filt_d[i]   = ~filt_q[i];
          db_cnt_d[i] = {DB_W{1'b0}};
        end else begin
          filt_d[i]   = filt_q[i];
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end else begin
        filt_d[i]   = filt_q[i];
        db_cnt_d[i] = {DB_W{1'b0}};
      end
    end
  end

  // Quadrature decode: classify the filtered pair change and advance the phase accumulator.
  always_comb begin
    diff_s    = phase_idx(filt_q[0], filt_q[1]) - phase_idx(ab_prev_q[0], ab_prev_q[1]);
    at_rest_s = (filt_q[1:0] == 2'b00);
    ph_d      = ph_q;
    step_s    = 1'b0;
    step_cw_s = 1'b0;
    illegal_s = 1'b0;
    case (diff_s)
      2'b01: begin
        if (at_rest_s) begin
          ph_d = 3'sd0;
          if (ph_q == PH_MAX) begin
            step_s    = 1'b1;
            step_cw_s = 1'b1;
          end else begin
            step_s    = 1'b0;
          end
        end else begin
          ph_d = ph_q + 3'sd1;
        end
      end
      2'b11: begin
        if (at_rest_s) begin
          ph_d = 3'sd0;
          if (ph_q == PH_MIN) begin
            step_s = 1'b1;
          end else begin
            step_s = 1'b0;
          end
        end else begin
          ph_d = ph_q - 3'sd1;
        end
      end
      // Both phases flipped at once: direction is unknowable.
      2'b10: begin
        illegal_s = 1'b1;
        ph_d      = 3'sd0;
      end
      default: ph_d = ph_q;
    endcase
  end

  // Output next-state: clear beats step for position, illegal beats clear for quad_err.
  always_comb begin
    step_valid_d  = step_s;
    step_dir_d    = step_dir_q;
    position_d    = position_q;
    quad_err_d    = quad_err_q;
    press_event_d = filt_q[2] & ~press_prev_q;
    if (step_s) begin
      step_dir_d = step_cw_s;
    end else begin
      step_dir_d = step_dir_q;
    end
    if (clr_pos) begin
      position_d = {C_CNT_WIDTH{1'b0}};
    end else if (step_s && step_cw_s) begin
      position_d = position_q + POS_ONE;
    end else if (step_s) begin
      position_d = position_q - POS_ONE;
    end else begin
      position_d = position_q;
    end
    if (illegal_s) begin
      quad_err_d = 1'b1;
    end else if (clr_pos) begin
      quad_err_d = 1'b0;
    end else begin
      quad_err_d = quad_err_q;
    end
  end

  // State register for synchronizers, debounce, decoder and outputs.
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      meta_q        <= 3'b000;
      sync_q        <= 3'b000;
      filt_q        <= 3'b000;
      db_cnt_q      <= {3{{DB_W{1'b0}}}};
      ab_prev_q     <= 2'b00;
      ph_q          <= 3'sd0;
      press_prev_q  <= 1'b0;
      step_valid_q  <= 1'b0;
      step_dir_q    <= 1'b0;
      position_q    <= {C_CNT_WIDTH{1'b0}};
      press_event_q <= 1'b0;
      quad_err_q    <= 1'b0;
    end else begin
      meta_q        <= raw_s;
      sync_q        <= meta_q;
      filt_q        <= filt_d;
      db_cnt_q      <= db_cnt_d;
      ab_prev_q     <= filt_q[1:0];
      ph_q          <= ph_d;
      press_prev_q  <= filt_q[2];
      step_valid_q  <= step_valid_d;
      step_dir_q    <= step_dir_d;
      position_q    <= position_d;
      press_event_q <= press_event_d;
      quad_err_q    <= quad_err_d;
    end
  end

  assign step_valid  = step_valid_q;
  assign step_dir    = step_dir_q;
  assign position    = position_q;
  assign press_level = filt_q[2];
  assign press_event = press_event_q;
  assign quad_err    = quad_err_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder (C_DEBOUNCE_CYCLES=4, C_CNT_WIDTH=16).
// Stimulus pushes expected {dir, position} per detent into a queue; the
// monitor pops on every step_valid pulse. The reference model works on
// positions along the CW gray cycle with plain integer arithmetic.
module tb_rotary_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ra = 1'b0, rb = 1'b0, rp = 1'b0, clr = 1'b0;
  logic step_valid, step_dir, press_level, press_event, quad_err;
  logic [15:0] position;

  int n_tests = 0;
  int n_fail = 0;
  int n_steps = 0;
  int n_press_ev = 0;
  logic [16:0] exp_q[$];

  // reference model state
  int m_ph = 0;
  int m_idx = 0;
  logic [15:0] m_pos = 16'd0;
  logic m_err = 1'b0;
  bit idx_a[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit idx_b[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic lvl_h0 = 1'b0, lvl_h1 = 1'b0;

  rotary_decoder #(.C_DEBOUNCE_CYCLES(4), .C_CNT_WIDTH(16)) dut (
    .SPLB_Clk(clk), .SPLB_Rst_n(rst_n), .rotary_a(ra), .rotary_b(rb),
    .rotary_press(rp), .clr_pos(clr), .step_valid(step_valid), .step_dir(step_dir),
    .position(position), .press_level(press_level), .press_event(press_event),
    .quad_err(quad_err));

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: compare every step pulse and press pulse.
  always @(negedge clk) begin
    logic [16:0] e;
    if (step_valid === 1'b1) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        check("unexpected_step", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("step_dir", {31'd0, step_dir}, {31'd0, e[16]});
        check("step_position", {16'd0, position}, {16'd0, e[15:0]});
      end
    end
    if (press_event === 1'b1) begin
      n_press_ev++;
      check("press_event_timing", {30'd0, lvl_h1, lvl_h0}, 32'd1);
    end
    lvl_h1 = lvl_h0;
    lvl_h0 = press_level;
  end

  task automatic model_update(int nidx, bit clr_now);
    int d;
    bit st;
    bit dir;
    d = (nidx - m_idx + 4) % 4;
    st = 1'b0;
    dir = 1'b0;
    if (d == 1) m_ph++;
    else if (d == 3) m_ph--;
    else if (d == 2) begin m_err = 1'b1; m_ph = 0; end
    if (nidx == 0 && (d == 1 || d == 3)) begin
      if (m_ph == 4) begin st = 1'b1; dir = 1'b1; m_pos = m_pos + 16'd1; end
      else if (m_ph == -4) begin st = 1'b1; dir = 1'b0; m_pos = m_pos - 16'd1; end
      m_ph = 0;
    end
    m_idx = nidx;
    if (clr_now) begin m_pos = 16'd0; m_err = 1'b0; end
    if (st) exp_q.push_back({dir, m_pos});
  endtask

  // Move the encoder to gray index nidx and hold; optionally strobe clr_pos
  // on the cycle the decoder registers the new state (raw edge + 7 clocks).
  task automatic move(int nidx, int hold, bit clr_at_entry);
    model_update(nidx, clr_at_entry);
    @(posedge clk); #1;
    ra = idx_a[nidx];
    rb = idx_b[nidx];
    if (clr_at_entry) begin
      repeat (6) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      repeat (hold - 7) @(posedge clk);
    end else begin
      repeat (hold) @(posedge clk);
    end
    #1;
    check("position", {16'd0, position}, {16'd0, m_pos});
    check("quad_err", {31'd0, quad_err}, {31'd0, m_err});
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m_pos = 16'd0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("clr_position", {16'd0, position}, 32'd0);
    check("clr_quad_err", {31'd0, quad_err}, 32'd0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_step_valid"}, {31'd0, step_valid}, 32'd0);
    check({tag, "_step_dir"}, {31'd0, step_dir}, 32'd0);
    check({tag, "_position"}, {16'd0, position}, 32'd0);
    check({tag, "_press_level"}, {31'd0, press_level}, 32'd0);
    check({tag, "_press_event"}, {31'd0, press_event}, 32'd0);
    check({tag, "_quad_err"}, {31'd0, quad_err}, 32'd0);
  endtask

  initial begin
    int steps_before;
    int r;
    int nidx;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // one clockwise detent
    move(1, 10, 1'b0); move(2, 10, 1'b0); move(3, 10, 1'b0); move(0, 10, 1'b0);
    check("cw_step_count", n_steps, 32'd1);

    // 3-cycle glitch on A must be filtered out
    steps_before = n_steps;
    @(posedge clk); #1 ra = 1'b1;
    repeat (3) @(posedge clk);
    #1 ra = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("glitch_steps", n_steps, steps_before);
    check("glitch_position", {16'd0, position}, 32'd1);

    // counter-clockwise from zero wraps, then two clockwise detents
    pulse_clr();
    move(3, 10, 1'b0); move(2, 10, 1'b0); move(1, 10, 1'b0); move(0, 10, 1'b0);
    for (int k = 0; k < 2; k++) begin
      move(1, 10, 1'b0); move(2, 10, 1'b0); move(3, 10, 1'b0); move(0, 10, 1'b0);
    end

    // illegal 00->11, then clear, then legal walk back to rest
    move(2, 10, 1'b0);
    pulse_clr();
    move(3, 10, 1'b0); move(0, 10, 1'b0);

    // backtracking gives no step
    steps_before = n_steps;
    move(1, 10, 1'b0); move(2, 10, 1'b0); move(1, 10, 1'b0); move(0, 10, 1'b0);
    check("backtrack_steps", n_steps, steps_before);

    // clear coincident with a clockwise step: step still issued, position 0
    move(1, 10, 1'b0); move(2, 10, 1'b0); move(3, 10, 1'b0); move(0, 12, 1'b1);

    // random walk with occasional illegal jumps and clears
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) nidx = (m_idx + 2) % 4;
      else if (r <= 5) nidx = (m_idx + 1) % 4;
      else nidx = (m_idx + 3) % 4;
      move(nidx, $urandom_range(9, 14), 1'b0);
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end
    if (m_idx != 0) begin
      while (m_idx != 0) move((m_idx + 1) % 4, 10, 1'b0);
    end
    pulse_clr();

    // push switch held 20 cycles, then released
    @(posedge clk); #1 rp = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("press_level_high", {31'd0, press_level}, 32'd1);
    check("press_event_count", n_press_ev, 32'd1);
    rp = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("press_level_low", {31'd0, press_level}, 32'd0);
    check("release_no_event", n_press_ev, 32'd1);

    // reset mid-hold and mid-rotation
    rp = 1'b1;
    move(1, 10, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #2 check_all_zero("midreset");
    m_pos = 16'd0; m_err = 1'b0; m_ph = 0; m_idx = 0;
    steps_before = n_steps;
    repeat (3) @(posedge clk);
    #1 rp = 1'b0;
    rst_n = 1'b1;
    // A still held high: filtered 00->10 is an ordinary transition
    model_update(1, 1'b0);
    repeat (12) @(posedge clk);
    #1 check("post_reset_steps", n_steps, steps_before);
    check("post_reset_position", {16'd0, position}, 32'd0);
    check("post_reset_press_events", n_press_ev, 32'd2);
    move(2, 10, 1'b0); move(3, 10, 1'b0); move(0, 10, 1'b0);
    check("post_reset_step_count", n_steps, steps_before + 1);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
